// File: rtl/spi_slave_burst_if.sv
// Register-bus side of the SPI slave: address/strobe/data toward the register file
// and the read-data handshake back from it.
interface spi_slave_burst_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic                  reg_wr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  reg_rd;
  logic                  reg_rd_ack;
  logic [DATA_WIDTH-1:0] reg_rdata;

  modport master (
    output reg_addr, reg_wr, reg_wdata, reg_rd,
    input  reg_rd_ack, reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wr, reg_wdata, reg_rd,
    output reg_rd_ack, reg_rdata
  );
endinterface

// File: rtl/spi_slave_burst.sv
// SPI slave bridging MCU frames [rw | addr | word0 | word1 ...] onto the register bus,
// with all four SPI modes, burst auto-increment and read prefetch/underrun detection.
module spi_slave_burst #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 24,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int BURST_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sck,
  input  logic               ncs,
  input  logic               si,
  output logic               so,
  output logic               so_oe,
  spi_slave_burst_if.master  bus,
  output logic               frame_active,
  output logic               frame_err,
  output logic               rd_underrun
);

  typedef enum logic [1:0] {IDLE, HEADER, WDATA, RDATA} state_t;

  localparam int HDR_BITS = ADDR_WIDTH + 1;
  localparam int MAX_BITS = (HDR_BITS > DATA_WIDTH) ? HDR_BITS : DATA_WIDTH;
  localparam int CW       = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_BITS - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH - 1);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);
  localparam logic SCK_IDLE  = (CPOL != 0);
  localparam bit BURST       = (BURST_EN != 0);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic [SYNC_STAGES-1:0] si_sync_q, si_sync_d;
  logic sck_prev_q, sck_prev_d, ncs_prev_q, ncs_prev_d;

  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] hdr_sr_q, hdr_sr_d;
  logic [DATA_WIDTH-2:0] wsr_q, wsr_d;
  logic [DATA_WIDTH-2:0] osr_q, osr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic hold_valid_q, hold_valid_d;
  logic rd_pend_q, rd_pend_d;
  logic word_start_q, word_start_d;
  logic ignore_q, ignore_d;
  logic any_word_q, any_word_d;
  logic prefetch_q, prefetch_d;

  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
  logic so_q, so_d, so_oe_q, so_oe_d;
  logic frame_err_q, frame_err_d, underrun_q, underrun_d;

  logic sck_s, ncs_s, si_s;
  logic sample_edge, shift_edge, ncs_fall, ncs_rise;
  logic hdr_last, word_last;

  always_comb begin
    sck_sync_d = SYNC_STAGES'({sck_sync_q, sck});
    ncs_sync_d = SYNC_STAGES'({ncs_sync_q, ncs});
    si_sync_d  = SYNC_STAGES'({si_sync_q, si});
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    ncs_s      = ncs_sync_q[SYNC_STAGES-1];
    si_s       = si_sync_q[SYNC_STAGES-1];
    sck_prev_d = sck_s;
    ncs_prev_d = ncs_s;
  end

  always_comb begin
    sample_edge = SAMPLE_RISE ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q);
    shift_edge  = SAMPLE_RISE ? (~sck_s & sck_prev_q) : (sck_s & ~sck_prev_q);
    ncs_fall    = ncs_prev_q & ~ncs_s;
    ncs_rise    = ~ncs_prev_q & ncs_s;
    hdr_last    = (state_q == HEADER) && sample_edge && (bit_cnt_q == HDR_LAST);
    word_last   = ((state_q == WDATA) || (state_q == RDATA)) && sample_edge &&
                  !ignore_q && (bit_cnt_q == WORD_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = HEADER;
      HEADER:  if (hdr_last) state_d = hdr_sr_q[ADDR_WIDTH-1] ? RDATA : WDATA;
      default: state_d = state_q;
    endcase
    if (ncs_rise) state_d = IDLE;
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    hdr_sr_d     = hdr_sr_q;
    wsr_d        = wsr_q;
    osr_d        = osr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rd_pend_d    = rd_pend_q;
    word_start_d = word_start_q;
    ignore_d     = ignore_q;
    any_word_d   = any_word_q;
    prefetch_d   = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wr_d     = 1'b0;
    reg_rd_d     = 1'b0;
    so_d         = so_q;
    frame_err_d  = 1'b0;
    underrun_d   = 1'b0;

    if (reg_wr_q && BURST) reg_addr_d = reg_addr_q + 1'b1;
    if (reg_rd_ack_ok()) begin
      hold_d       = bus.reg_rdata;
      hold_valid_d = 1'b1;
      rd_pend_d    = 1'b0;
    end
    if (prefetch_q) begin
      reg_addr_d = reg_addr_q + 1'b1;
      reg_rd_d   = 1'b1;
      rd_pend_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        so_d = 1'b0;
        if (ncs_fall) begin
          bit_cnt_d    = '0;
          hdr_sr_d     = '0;
          wsr_d        = '0;
          osr_d        = '0;
          hold_valid_d = 1'b0;
          rd_pend_d    = 1'b0;
          word_start_d = 1'b0;
          ignore_d     = 1'b0;
          any_word_d   = 1'b0;
        end
      end
      HEADER: begin
        if (sample_edge) begin
          hdr_sr_d  = ADDR_WIDTH'({hdr_sr_q, si_s});
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (hdr_last) begin
            bit_cnt_d  = '0;
            reg_addr_d = ADDR_WIDTH'({hdr_sr_q, si_s});
            if (hdr_sr_q[ADDR_WIDTH-1]) begin
              reg_rd_d     = 1'b1;
              rd_pend_d    = 1'b1;
              word_start_d = 1'b1;
            end
          end
        end
      end
      WDATA: begin
        if (sample_edge && !ignore_q) begin
          wsr_d     = (DATA_WIDTH-1)'({wsr_q, si_s});
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (word_last) begin
            bit_cnt_d   = '0;
            reg_wr_d    = 1'b1;
            reg_wdata_d = {wsr_q, si_s};
            any_word_d  = 1'b1;
            ignore_d    = !BURST;
          end
        end
      end
      RDATA: begin
        if (ignore_q) begin
          so_d = 1'b0;
        end else if (shift_edge) begin
          // A word's first shift edge swaps in the hold buffer; any ack arriving later is stale.
          if (word_start_q) begin
            if (hold_valid_q) begin
              osr_d = hold_q[DATA_WIDTH-2:0];
              so_d  = hold_q[DATA_WIDTH-1];
            end else begin
              osr_d      = '0;
              so_d       = 1'b0;
              underrun_d = 1'b1;
            end
            hold_valid_d = 1'b0;
            rd_pend_d    = 1'b0;
            word_start_d = 1'b0;
            prefetch_d   = BURST;
          end else begin
            so_d  = osr_q[DATA_WIDTH-2];
            osr_d = (DATA_WIDTH-1)'({osr_q, 1'b0});
          end
        end else if (sample_edge) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (word_last) begin
            bit_cnt_d    = '0;
            any_word_d   = 1'b1;
            word_start_d = 1'b1;
            ignore_d     = !BURST;
          end
        end
      end
      default: so_d = 1'b0;
    endcase

    // Error is judged on the post-edge counters so a final bit landing with ncs rise still completes.
    if (ncs_rise && (state_q != IDLE)) begin
      frame_err_d = ((state_q == HEADER) && !hdr_last) || (bit_cnt_d != '0) || !any_word_d;
      so_d        = 1'b0;
      reg_rd_d    = 1'b0;
      rd_pend_d   = 1'b0;
      prefetch_d  = 1'b0;
    end

    so_oe_d = (state_d == RDATA);
  end

  function automatic logic reg_rd_ack_ok();
    return bus.reg_rd_ack && rd_pend_q;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q   <= {SYNC_STAGES{SCK_IDLE}};
      ncs_sync_q   <= '1;
      si_sync_q    <= '0;
      sck_prev_q   <= SCK_IDLE;
      ncs_prev_q   <= 1'b1;
      bit_cnt_q    <= '0;
      hdr_sr_q     <= '0;
      wsr_q        <= '0;
      osr_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      word_start_q <= 1'b0;
      ignore_q     <= 1'b0;
      any_word_q   <= 1'b0;
      prefetch_q   <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_wr_q     <= 1'b0;
      reg_rd_q     <= 1'b0;
      so_q         <= 1'b0;
      so_oe_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      ncs_sync_q   <= ncs_sync_d;
      si_sync_q    <= si_sync_d;
      sck_prev_q   <= sck_prev_d;
      ncs_prev_q   <= ncs_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      hdr_sr_q     <= hdr_sr_d;
      wsr_q        <= wsr_d;
      osr_q        <= osr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rd_pend_q    <= rd_pend_d;
      word_start_q <= word_start_d;
      ignore_q     <= ignore_d;
      any_word_q   <= any_word_d;
      prefetch_q   <= prefetch_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wr_q     <= reg_wr_d;
      reg_rd_q     <= reg_rd_d;
      so_q         <= so_d;
      so_oe_q      <= so_oe_d;
      frame_err_q  <= frame_err_d;
      underrun_q   <= underrun_d;
    end
  end

  assign so           = so_q & so_oe_q;
  assign so_oe        = so_oe_q;
  assign frame_active = (state_q != IDLE);
  assign frame_err    = frame_err_q;
  assign rd_underrun  = underrun_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_rd    = reg_rd_q;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench: a mode-0 and a mode-3 slave share one bit-banged SPI master;
// a negedge monitor logs bus strobes and answers reads two clocks after each reg_rd.
module tb_spi_slave_burst;
  localparam int AW = 7;
  localparam int DW = 24;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic sel3 = 1'b0, sck_m = 1'b0, ncs_m = 1'b1, si_m = 1'b0;
  logic sck0, ncs0, si0, so0, so_oe0, fa0, fe0, ur0;
  logic sck3, ncs3, si3, so3, so_oe3, fa3, fe3, ur3;
  logic so_m;

  assign sck0 = sel3 ? 1'b0 : sck_m;
  assign ncs0 = sel3 ? 1'b1 : ncs_m;
  assign si0  = si_m;
  assign sck3 = sel3 ? sck_m : 1'b1;
  assign ncs3 = sel3 ? ncs_m : 1'b1;
  assign si3  = si_m;
  assign so_m = sel3 ? so3 : so0;

  spi_slave_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  spi_slave_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  assign bus3.reg_rd_ack = 1'b0;
  assign bus3.reg_rdata  = '0;

  spi_slave_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPOL(0), .CPHA(0),
                    .SYNC_STAGES(2), .BURST_EN(1)) dut0 (
    .clk(clk), .rst(rst), .sck(sck0), .ncs(ncs0), .si(si0), .so(so0), .so_oe(so_oe0),
    .bus(bus0.master), .frame_active(fa0), .frame_err(fe0), .rd_underrun(ur0));

  spi_slave_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPOL(1), .CPHA(1),
                    .SYNC_STAGES(2), .BURST_EN(1)) dut3 (
    .clk(clk), .rst(rst), .sck(sck3), .ncs(ncs3), .si(si3), .so(so3), .so_oe(so_oe3),
    .bus(bus3.master), .frame_active(fa3), .frame_err(fe3), .rd_underrun(ur3));

  logic [AW-1:0] wr0_a[$], rd0_a[$], wr3_a[$];
  logic [DW-1:0] wr0_d[$], wr3_d[$];
  int fe0_n = 0, ur0_n = 0, fe3_n = 0;
  int skip_idx = -1;
  int ack_t = 0;
  logic [DW-1:0] ack_v = '0;

  int vectors = 0, miscompares = 0;
  logic [127:0] rx;

  function automatic logic [DW-1:0] rdata_for(input logic [AW-1:0] a);
    case (a)
      7'h7F:   return 24'h111111;
      7'h00:   return 24'h222222;
      7'h01:   return 24'h333333;
      default: return {3{1'b0, a}};
    endcase
  endfunction

  always @(negedge clk) begin
    bus0.reg_rd_ack = (ack_t == 1);
    bus0.reg_rdata  = (ack_t == 1) ? ack_v : '0;
    if (ack_t > 0) ack_t--;
    if (bus0.reg_rd) begin
      if (rd0_a.size() != skip_idx) begin
        ack_t = 2;
        ack_v = rdata_for(bus0.reg_addr);
      end
      rd0_a.push_back(bus0.reg_addr);
    end
    if (bus0.reg_wr) begin
      wr0_a.push_back(bus0.reg_addr);
      wr0_d.push_back(bus0.reg_wdata);
    end
    if (bus3.reg_wr) begin
      wr3_a.push_back(bus3.reg_addr);
      wr3_d.push_back(bus3.reg_wdata);
    end
    if (fe0) fe0_n++;
    if (ur0) ur0_n++;
    if (fe3) fe3_n++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int nbits, input logic [127:0] tx, input logic cpol, input logic cpha);
    sck_m = cpol;
    ncs_m = 1'b0;
    rx    = '0;
    wait_clk(H);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        si_m = tx[i];
        wait_clk(H);
        sck_m = ~cpol;
        rx = {rx[126:0], so_m};
        wait_clk(H);
        sck_m = cpol;
      end else begin
        sck_m = ~cpol;
        si_m  = tx[i];
        wait_clk(H);
        sck_m = cpol;
        rx = {rx[126:0], so_m};
        wait_clk(H);
      end
    end
    wait_clk(H);
    ncs_m = 1'b1;
    si_m  = 1'b0;
    wait_clk(4 * H);
  endtask

  function automatic logic [127:0] outs0();
    return {so0, so_oe0, fa0, fe0, ur0, bus0.reg_wr, bus0.reg_rd, bus0.reg_addr, bus0.reg_wdata};
  endfunction

  initial begin
    int bw, br, bf, bu;
    rst = 1'b0;
    wait_clk(3);
    check("reset_outs0", outs0(), '0);
    check("reset_outs3", {so3, so_oe3, fa3, fe3, ur3, bus3.reg_wr, bus3.reg_rd,
                          bus3.reg_addr, bus3.reg_wdata}, '0);
    rst = 1'b1;
    wait_clk(4);

    // mode 0 single write
    bw = wr0_a.size(); bf = fe0_n;
    frame(32, {1'b0, 7'h12, 24'hABCDEF}, 1'b0, 1'b0);
    check("t1_wr_count", wr0_a.size() - bw, 1);
    check("t1_wr_addr", wr0_a[bw], 7'h12);
    check("t1_wr_data", wr0_d[bw], 24'hABCDEF);
    check("t1_frame_err", fe0_n - bf, 0);

    // mode 0 burst read wrapping 0x7F -> 0x00
    br = rd0_a.size(); bf = fe0_n; bu = ur0_n;
    frame(80, {1'b1, 7'h7F, 72'h0}, 1'b0, 1'b0);
    check("t2_so_data", rx[79:0], {8'h00, 72'h111111_222222_333333});
    check("t2_rd_addr0", rd0_a[br], 7'h7F);
    check("t2_rd_addr1", rd0_a[br + 1], 7'h00);
    check("t2_rd_addr2", rd0_a[br + 2], 7'h01);
    check("t2_underrun", ur0_n - bu, 0);
    check("t2_frame_err", fe0_n - bf, 0);

    // mode 3 burst write
    sck_m = 1'b1;
    sel3  = 1'b1;
    wait_clk(4);
    bw = wr3_a.size(); bf = fe3_n;
    frame(56, {1'b0, 7'h05, 24'h123456, 24'h789ABC}, 1'b1, 1'b1);
    check("t3_wr_count", wr3_a.size() - bw, 2);
    check("t3_wr_addr0", wr3_a[bw], 7'h05);
    check("t3_wr_data0", wr3_d[bw], 24'h123456);
    check("t3_wr_addr1", wr3_a[bw + 1], 7'h06);
    check("t3_wr_data1", wr3_d[bw + 1], 24'h789ABC);
    check("t3_frame_err", fe3_n - bf, 0);
    sel3  = 1'b0;
    sck_m = 1'b0;
    wait_clk(4);

    // read whose first request is never acked
    br = rd0_a.size(); bu = ur0_n; bf = fe0_n;
    skip_idx = br;
    frame(32, {1'b1, 7'h20, 24'h0}, 1'b0, 1'b0);
    skip_idx = -1;
    check("t4_rd_addr", rd0_a[br], 7'h20);
    check("t4_so_data", rx[23:0], 24'h000000);
    check("t4_underrun", ur0_n - bu, 1);
    check("t4_frame_err", fe0_n - bf, 0);

    // write aborted after 10 data bits
    bw = wr0_a.size(); bf = fe0_n;
    frame(18, {1'b0, 7'h33, 10'h2AA}, 1'b0, 1'b0);
    check("t5_wr_count", wr0_a.size() - bw, 0);
    check("t5_frame_err", fe0_n - bf, 1);
    check("t5_frame_active", fa0, 1'b0);

    // asynchronous reset in the middle of a read
    fork
      frame(80, {1'b1, 7'h01, 72'h0}, 1'b0, 1'b0);
      begin
        wait_clk(300);
        check("t6_active_before", {fa0, so_oe0}, 2'b11);
        #3 rst = 1'b0;
        #1 check("t6_outs_in_reset", outs0(), '0);
      end
    join
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    bw = wr0_a.size(); bf = fe0_n;
    frame(32, {1'b0, 7'h44, 24'h5A5A5A}, 1'b0, 1'b0);
    check("t6_wr_count", wr0_a.size() - bw, 1);
    check("t6_wr_addr", wr0_a[bw], 7'h44);
    check("t6_wr_data", wr0_d[bw], 24'h5A5A5A);
    check("t6_frame_err", fe0_n - bf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
